// File: rtl/race_start_sequencer.sv
// Lobby-to-race start sequencer: counts ready players, runs an abortable
// countdown, then issues a one-cycle go pulse with the latched participant mask.
module race_start_sequencer #(
    parameter int NUM_PLAYERS      = 4,
    parameter int MIN_READY        = 2,
    parameter int TICK_CLK_COUNT   = 50000000,
    parameter int COUNTDOWN_START  = 7,
    parameter int ABORT_ON_UNREADY = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PLAYERS-1:0]                 ready,
    input  logic                                   restart,
    output logic                                   is_in_menu,
    output logic [$clog2(COUNTDOWN_START+1)-1:0]   countdown,
    output logic                                   activity,
    output logic                                   go,
    output logic [NUM_PLAYERS-1:0]                 participants,
    output logic [$clog2(NUM_PLAYERS+1)-1:0]       ready_count
);

    localparam int CW  = $clog2(COUNTDOWN_START + 1);
    localparam int RCW = $clog2(NUM_PLAYERS + 1);
    localparam int TW  = $clog2(TICK_CLK_COUNT);

    localparam logic [CW-1:0]  CD_START    = CW'(COUNTDOWN_START);
    localparam logic [RCW-1:0] MIN_READY_C = RCW'(MIN_READY);
    localparam logic [TW-1:0]  TICK_LAST   = TW'(TICK_CLK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        RACING   = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [TW-1:0]           tick_cnt, tick_cnt_next;
    logic [CW-1:0]           countdown_next;
    logic                    go_next;
    logic [NUM_PLAYERS-1:0]  participants_next;
    logic                    enough;
    logic                    tick;

    always_comb begin
        ready_count = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            ready_count = ready_count + RCW'(ready[i]);
        end
    end

    assign enough     = (ready_count >= MIN_READY_C);
    assign tick       = (state == COUNTING) && (tick_cnt == TICK_LAST);
    assign activity   = tick;
    assign is_in_menu = (state != RACING);

    // Leaving COUNTING for any reason leaves the tick counter at 0, so the
    // next countdown always starts with a full first step.
    always_comb begin
        state_next        = state;
        countdown_next    = countdown;
        tick_cnt_next     = '0;
        go_next           = 1'b0;
        participants_next = participants;
        case (state)
            IDLE: begin
                countdown_next = '0;
                if (enough && !restart) begin
                    state_next     = COUNTING;
                    countdown_next = CD_START;
                end
            end
            COUNTING: begin
                if (restart) begin
                    state_next     = IDLE;
                    countdown_next = '0;
                end else if (!enough && (ABORT_ON_UNREADY != 0)) begin
                    state_next     = IDLE;
                    countdown_next = '0;
                end else if (tick && (countdown == CW'(1))) begin
                    state_next        = RACING;
                    countdown_next    = '0;
                    participants_next = ready;
                    go_next           = 1'b1;
                end else begin
                    if (tick) begin
                        countdown_next = countdown - CW'(1);
                    end
                    tick_cnt_next = tick ? '0 : tick_cnt + TW'(1);
                end
            end
            RACING: begin
                countdown_next = '0;
                if (restart) begin
                    state_next        = IDLE;
                    participants_next = '0;
                end
            end
            default: begin
                state_next        = IDLE;
                countdown_next    = '0;
                participants_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            countdown    <= '0;
            go           <= 1'b0;
            participants <= '0;
        end else begin
            state        <= state_next;
            tick_cnt     <= tick_cnt_next;
            countdown    <= countdown_next;
            go           <= go_next;
            participants <= participants_next;
        end
    end

endmodule

// File: tb/tb_race_start_sequencer.sv
// Bench for race_start_sequencer: vector tables with a scoreboard queue, run
// against an aborting instance and a non-aborting instance sharing stimulus.
module tb_race_start_sequencer;

    typedef struct {
        logic       sel;      // 0: aborting instance, 1: non-aborting instance
        logic [3:0] rdy;
        logic       rst_req;
        logic [1:0] cd;
        logic       act;
        logic       go;
        logic       menu;
        logic [3:0] parts;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] ready;
    logic       restart;

    logic       menu_a, act_a, go_a;
    logic [1:0] cd_a;
    logic [3:0] parts_a;
    logic [2:0] rc_a;
    logic       menu_n, act_n, go_n;
    logic [1:0] cd_n;
    logic [3:0] parts_n;
    logic [2:0] rc_n;

    vec_t  tbl[$];
    vec_t  exp_q[$];
    int    n_total;
    int    n_pass;
    string cur_name;
    int    vec_idx;

    race_start_sequencer #(
        .NUM_PLAYERS(4), .MIN_READY(2), .TICK_CLK_COUNT(4),
        .COUNTDOWN_START(3), .ABORT_ON_UNREADY(1)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .restart(restart),
        .is_in_menu(menu_a), .countdown(cd_a), .activity(act_a), .go(go_a),
        .participants(parts_a), .ready_count(rc_a)
    );

    race_start_sequencer #(
        .NUM_PLAYERS(4), .MIN_READY(2), .TICK_CLK_COUNT(4),
        .COUNTDOWN_START(3), .ABORT_ON_UNREADY(0)
    ) dut_na (
        .clk(clk), .reset(reset), .ready(ready), .restart(restart),
        .is_in_menu(menu_n), .countdown(cd_n), .activity(act_n), .go(go_n),
        .participants(parts_n), .ready_count(rc_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(logic sel, logic [3:0] rdy, logic rs, logic [1:0] cd,
                                logic act, logic g, logic menu, logic [3:0] parts);
        vec_t v;
        v.sel = sel; v.rdy = rdy; v.rst_req = rs; v.cd = cd;
        v.act = act; v.go = g; v.menu = menu; v.parts = parts;
        return v;
    endfunction

    task automatic check_pop();
        vec_t       e;
        logic [1:0] a_cd;
        logic       a_act, a_go, a_menu;
        logic [3:0] a_p;
        logic [2:0] a_rc, e_rc;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s[%0d]: scoreboard empty, nothing expected", cur_name, vec_idx);
            return;
        end
        e = exp_q.pop_front();
        if (e.sel) begin
            a_cd = cd_n; a_act = act_n; a_go = go_n; a_menu = menu_n; a_p = parts_n; a_rc = rc_n;
        end else begin
            a_cd = cd_a; a_act = act_a; a_go = go_a; a_menu = menu_a; a_p = parts_a; a_rc = rc_a;
        end
        e_rc = 3'($countones(e.rdy));
        if (a_cd === e.cd && a_act === e.act && a_go === e.go && a_menu === e.menu &&
            a_p === e.parts && a_rc === e_rc) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got cd=%0d act=%b go=%b menu=%b parts=%b rc=%0d, expected cd=%0d act=%b go=%b menu=%b parts=%b rc=%0d",
                     cur_name, vec_idx, a_cd, a_act, a_go, a_menu, a_p, a_rc,
                     e.cd, e.act, e.go, e.menu, e.parts, e_rc);
        end
    endtask

    task automatic apply(input vec_t v);
        ready   = v.rdy;
        restart = v.rst_req;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic run_table(input string name);
        cur_name = name;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_idx = i;
            apply(tbl[i]);
        end
        tbl.delete();
    endtask

    task automatic do_reset(input string name);
        cur_name = name;
        ready    = 4'b0000;
        restart  = 1'b0;
        reset    = 1'b0;
        #1;
        vec_idx = 0;
        exp_q.push_back(mk(0, 4'b0000, 0, 2'd0, 0, 0, 1, 4'b0000));
        check_pop();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        vec_idx = 1;
        exp_q.push_back(mk(1, 4'b0000, 0, 2'd0, 0, 0, 1, 4'b0000));
        check_pop();
    endtask

    // Rows 0..11 of a nominal countdown started from IDLE with ready=0011.
    task automatic push_count_rows(input logic sel);
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd3, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd2, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd2, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd2, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd2, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd1, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd1, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd1, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(sel, 4'b0011, 0, 2'd1, 1, 0, 1, 4'b0000));
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        vec_idx  = 0;
        reset    = 1'b1;
        ready    = 4'b0000;
        restart  = 1'b0;
        #2;

        do_reset("reset_values");

        // Nominal start, race, then restart back to the menu.
        push_count_rows(0);
        tbl.push_back(mk(0, 4'b0011, 0, 2'd0, 0, 1, 0, 4'b0011));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd0, 0, 0, 0, 4'b0011));
        tbl.push_back(mk(0, 4'b1100, 0, 2'd0, 0, 0, 0, 4'b0011));
        tbl.push_back(mk(0, 4'b0011, 1, 2'd0, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 0, 2'd0, 0, 0, 1, 4'b0000));
        run_table("nominal");

        do_reset("reset_b");
        for (int i = 0; i < 50; i++) begin
            tbl.push_back(mk(0, 4'b0001, 0, 2'd0, 0, 0, 1, 4'b0000));
        end
        run_table("single_ready");

        // Abort at countdown=2, then re-entry restarts from 3 with a full step.
        do_reset("reset_c");
        tbl.push_back(mk(0, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd3, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd2, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 0, 2'd0, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd3, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd2, 0, 0, 1, 4'b0000));
        run_table("abort");

        // Same readiness dip on the non-aborting instance: go at the nominal edge.
        do_reset("reset_d");
        tbl.push_back(mk(1, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd3, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd2, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0001, 0, 2'd2, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0001, 0, 2'd2, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd2, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd1, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd1, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd1, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd1, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(1, 4'b0111, 0, 2'd0, 0, 1, 0, 4'b0111));
        tbl.push_back(mk(1, 4'b0011, 0, 2'd0, 0, 0, 0, 4'b0111));
        run_table("no_abort");

        // Readiness lost on the final tick, then restart held while enough in IDLE.
        do_reset("reset_e");
        push_count_rows(0);
        tbl.push_back(mk(0, 4'b0001, 0, 2'd0, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 0, 2'd0, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 1, 2'd0, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0011, 0, 2'd3, 0, 0, 1, 4'b0000));
        run_table("final_tick");

        // Restart coinciding with the final tick also suppresses go.
        do_reset("reset_f");
        push_count_rows(0);
        tbl.push_back(mk(0, 4'b0011, 1, 2'd0, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 0, 2'd0, 0, 0, 1, 4'b0000));
        run_table("restart_tick");

        // Asynchronous reset between edges while countdown=2.
        do_reset("reset_g");
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(tbl.size() == 3 ? mk(0, 4'b0011, 0, 2'd3, 1, 0, 1, 4'b0000)
                        : mk(0, 4'b0011, 0, (i < 4) ? 2'd3 : 2'd2, 0, 0, 1, 4'b0000));
        end
        run_table("async_pre");
        #3;
        reset = 1'b0;
        #1;
        cur_name = "async_clear";
        vec_idx  = 0;
        exp_q.push_back(mk(0, 4'b0011, 0, 2'd0, 0, 0, 1, 4'b0000));
        check_pop();
        #1;
        reset = 1'b1;
        tbl.push_back(mk(0, 4'b1111, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 0, 2'd3, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 0, 2'd3, 1, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 0, 2'd2, 0, 0, 1, 4'b0000));
        run_table("async_restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
